// File: rtl/puf_key_lifecycle_ctrl_pkg.sv
// puf_key_lifecycle_ctrl_pkg: shared state encoding, mode values and error codes for the PUF key lifecycle controller
package puf_key_lifecycle_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FE_REQ,
        S_FE_WAIT,
        S_HASH_REQ,
        S_HASH_WAIT,
        S_READY,
        S_ERROR
    } state_t;
    localparam logic MODE_ENROLL = 1'b0;
    localparam logic MODE_RECON  = 1'b1;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FE_TO   = 2'd1;
    localparam logic [1:0] ERR_HASH_TO = 2'd2;
    localparam logic [1:0] ERR_RETRY   = 2'd3;
endpackage

// File: rtl/puf_key_lifecycle_ctrl_watchdog.sv
// keyctl_watchdog: per-phase cycle counter, saturating at TIMEOUT_CYC-1
//   clk, reset  clock, synchronous active-high reset
//   i_clear     zero the counter (asserted the cycle before a wait state)
//   i_en        count while in a wait state
//   o_expired   current wait cycle is the last allowed one
module keyctl_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear)
            r_cnt <= '0;
        else if (i_en && r_cnt != LAST)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = i_en && (r_cnt == LAST);
endmodule

// File: rtl/puf_key_lifecycle_ctrl.sv
// puf_key_lifecycle_ctrl: sequences fuzzy extractor then hash engine to derive and hold the PUF key
//   i_start/i_mode/i_helper_in   request (mode 0 enroll, 1 reconstruct), accepted in IDLE/READY/ERROR
//   i_zeroize                    clear secrets and return to IDLE, overrides start
//   o_fe_*/i_fe_*                fuzzy extractor handshake
//   o_hash_*/i_hash_*            hash engine handshake
//   i_hmac_req/o_hmac_*          HMAC start gating on key_valid
//   o_helper_*, o_key*, o_busy, o_err_code   status and results
module puf_key_lifecycle_ctrl
    import puf_key_lifecycle_ctrl_pkg::*;
#(
    parameter int FE_BLOCKS   = 22,
    parameter int KEY_W       = 512,
    parameter int TIMEOUT_CYC = 4096,
    parameter int MAX_RETRY   = 3,
    localparam int FE_W       = FE_BLOCKS * 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_zeroize,
    input  logic [FE_W-1:0]  i_helper_in,
    output logic             o_fe_start,
    output logic             o_fe_mode,
    output logic [FE_W-1:0]  o_fe_helper,
    input  logic             i_fe_done,
    input  logic             i_fe_fail,
    input  logic [FE_W-1:0]  i_fe_rprime,
    input  logic [FE_W-1:0]  i_fe_helper_out,
    output logic             o_hash_start,
    output logic [FE_W-1:0]  o_hash_msg,
    input  logic             i_hash_done,
    input  logic [KEY_W-1:0] i_hash_digest,
    input  logic             i_hmac_req,
    output logic             o_hmac_start,
    output logic             o_hmac_reject,
    output logic [FE_W-1:0]  o_helper_data,
    output logic             o_helper_valid,
    output logic [KEY_W-1:0] o_key,
    output logic             o_key_valid,
    output logic             o_busy,
    output logic [1:0]       o_err_code
);
    // one spare bit keeps the counter non-zero width when MAX_RETRY is 0
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t           r_state;
    logic [RW-1:0]    r_retry;
    logic             r_fe_start, r_fe_mode, r_hash_start, r_hmac_reject;
    logic             r_helper_valid, r_key_valid;
    logic [FE_W-1:0]  r_fe_helper, r_hash_msg, r_helper_data;
    logic [KEY_W-1:0] r_key;
    logic [1:0]       r_err;
    logic             w_expired;

    keyctl_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state == S_FE_REQ || r_state == S_HASH_REQ),
        .i_en      (r_state == S_FE_WAIT || r_state == S_HASH_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_retry        <= '0;
            r_fe_start     <= 1'b0;
            r_fe_mode      <= 1'b0;
            r_fe_helper    <= '0;
            r_hash_start   <= 1'b0;
            r_hash_msg     <= '0;
            r_hmac_reject  <= 1'b0;
            r_helper_data  <= '0;
            r_helper_valid <= 1'b0;
            r_key          <= '0;
            r_key_valid    <= 1'b0;
            r_err          <= ERR_NONE;
        end else begin
            r_fe_start    <= 1'b0;
            r_hash_start  <= 1'b0;
            r_hmac_reject <= i_hmac_req && !r_key_valid;
            if (i_zeroize) begin
                r_state        <= S_IDLE;
                r_retry        <= '0;
                r_hash_msg     <= '0;
                r_helper_data  <= '0;
                r_helper_valid <= 1'b0;
                r_key          <= '0;
                r_key_valid    <= 1'b0;
                r_err          <= ERR_NONE;
            end else begin
                case (r_state)
                    S_IDLE, S_READY, S_ERROR: if (i_start) begin
                        r_fe_mode   <= i_mode;
                        r_fe_helper <= (i_mode == MODE_RECON) ? i_helper_in : r_fe_helper;
                        r_helper_valid <= (i_mode == MODE_ENROLL) ? 1'b0 : r_helper_valid;
                        r_key       <= '0;
                        r_key_valid <= 1'b0;
                        r_err       <= ERR_NONE;
                        r_retry     <= '0;
                        r_fe_start  <= 1'b1;
                        r_state     <= S_FE_REQ;
                    end
                    S_FE_REQ: r_state <= S_FE_WAIT;
                    S_FE_WAIT: begin
                        // a decode failure only matters when reconstructing
                        if (i_fe_done && (!i_fe_fail || r_fe_mode == MODE_ENROLL)) begin
                            r_hash_msg <= i_fe_rprime;
                            if (r_fe_mode == MODE_ENROLL) begin
                                r_helper_data  <= i_fe_helper_out;
                                r_helper_valid <= 1'b1;
                            end
                            r_hash_start <= 1'b1;
                            r_state      <= S_HASH_REQ;
                        end else if (i_fe_done && r_retry < RW'(MAX_RETRY)) begin
                            r_retry    <= r_retry + 1'b1;
                            r_fe_start <= 1'b1;
                            r_state    <= S_FE_REQ;
                        end else if (i_fe_done || w_expired) begin
                            r_err       <= i_fe_done ? ERR_RETRY : ERR_FE_TO;
                            r_key       <= '0;
                            r_key_valid <= 1'b0;
                            r_hash_msg  <= '0;
                            r_state     <= S_ERROR;
                        end
                    end
                    S_HASH_REQ: r_state <= S_HASH_WAIT;
                    S_HASH_WAIT: begin
                        if (i_hash_done) begin
                            r_key       <= i_hash_digest;
                            r_key_valid <= 1'b1;
                            r_hash_msg  <= '0;
                            r_state     <= S_READY;
                        end else if (w_expired) begin
                            r_err       <= ERR_HASH_TO;
                            r_key       <= '0;
                            r_key_valid <= 1'b0;
                            r_hash_msg  <= '0;
                            r_state     <= S_ERROR;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_fe_start     = r_fe_start;
    assign o_fe_mode      = r_fe_mode;
    assign o_fe_helper    = r_fe_helper;
    assign o_hash_start   = r_hash_start;
    assign o_hash_msg     = r_hash_msg;
    assign o_hmac_start   = i_hmac_req && r_key_valid;
    assign o_hmac_reject  = r_hmac_reject;
    assign o_helper_data  = r_helper_data;
    assign o_helper_valid = r_helper_valid;
    assign o_key          = r_key;
    assign o_key_valid    = r_key_valid;
    assign o_busy         = !(r_state inside {S_IDLE, S_READY, S_ERROR});
    assign o_err_code     = r_err;
endmodule
